// File: rtl/bsg_manycore_pkg.sv
// Shared types for the manycore reset sequencer.
//   bsg_manycore_reset_seq_state_e : sequencer FSM states
//   safe_clog2                     : counter width helper, never returns 0
package bsg_manycore_pkg;

  typedef enum logic [2:0] {
    e_rs_idle,
    e_rs_hold,
    e_rs_io,
    e_rs_rows,
    e_rs_done
  } bsg_manycore_reset_seq_state_e;

  // Width needed to hold values 0..n-1, at least one bit.
  function automatic int unsigned safe_clog2(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bsg_manycore_reset_sync.sv
// Reset synchroniser: assertion passes straight through (async clear),
// deassertion is retimed through sync_stages_p flops.
//   clk_i     : clock
//   reset_n_i : raw active-low reset
//   reset_n_o : active-low reset, deassertion synchronous to clk_i
module bsg_manycore_reset_sync #(
  parameter int unsigned sync_stages_p = 2
) (
  input  logic clk_i,
  input  logic reset_n_i,
  output logic reset_n_o
);

  if (sync_stages_p < 2) begin : g_bad_stages
    $error("bsg_manycore_reset_sync: sync_stages_p must be >= 2");
  end

  logic [sync_stages_p-1:0] sync_q;

  // Shift ones in after release; any assertion clears the whole chain.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[sync_stages_p-2:0], 1'b1};
    end
  end

  assign reset_n_o = sync_q[sync_stages_p-1];

endmodule

// File: rtl/bsg_manycore_reset_sequencer.sv
// Staged reset release for the manycore array: IO-row routers first, then
// tile rows one at a time with row_gap_p cycles between releases. A software
// re-reset can be requested once the sequence is complete.
//   clk_i            : clock
//   reset_n_i        : chip reset, asynchronous active-low
//   sw_reset_v_i     : software re-reset request (taken when ready is high)
//   row_hold_i       : per tile row hold-in-reset (only with
//                      BSG_MANYCORE_RESET_SEQ_ROW_HOLD_EN defined)
//   sw_reset_ready_o : high only while the sequence is complete
//   io_reset_o       : active-high reset per IO router
//   tile_reset_o     : active-high reset per tile, [row][col], row 0 first
//   done_o           : sequence complete
// Optional feature macro: BSG_MANYCORE_RESET_SEQ_ROW_HOLD_EN
module bsg_manycore_reset_sequencer
  import bsg_manycore_pkg::*;
#(
  parameter int unsigned num_tiles_x_p = 4,
  parameter int unsigned num_tiles_y_p = 5,
  parameter int unsigned sync_stages_p = 2,
  parameter int unsigned hold_cycles_p = 8,
  parameter int unsigned row_gap_p     = 2
) (
  input  logic                                         clk_i,
  input  logic                                         reset_n_i,
  input  logic                                         sw_reset_v_i,
`ifdef BSG_MANYCORE_RESET_SEQ_ROW_HOLD_EN
  input  logic [num_tiles_y_p-2:0]                     row_hold_i,
`endif
  output logic                                         sw_reset_ready_o,
  output logic [num_tiles_x_p-1:0]                     io_reset_o,
  output logic [(num_tiles_y_p-1)*num_tiles_x_p-1:0]   tile_reset_o,
  output logic                                         done_o
);

  localparam int unsigned cols_lp   = num_tiles_x_p;
  localparam int unsigned rows_lp   = num_tiles_y_p - 1;
  localparam int unsigned tiles_lp  = rows_lp * cols_lp;
  localparam int unsigned gap_w_lp  = safe_clog2(row_gap_p + 1);
  localparam int unsigned hold_w_lp = safe_clog2(hold_cycles_p + 1);
  localparam int unsigned row_w_lp  = safe_clog2(num_tiles_y_p);

  if (num_tiles_x_p < 1) begin : g_bad_x
    $error("bsg_manycore_reset_sequencer: num_tiles_x_p must be > 0");
  end
  if (num_tiles_y_p < 2) begin : g_bad_y
    $error("bsg_manycore_reset_sequencer: num_tiles_y_p must be >= 2");
  end
  if (hold_cycles_p < 1 || row_gap_p < 1) begin : g_bad_timing
    $error("bsg_manycore_reset_sequencer: hold_cycles_p and row_gap_p must be >= 1");
  end

  logic reset_sync_n;

  bsg_manycore_reset_sync #(
    .sync_stages_p(sync_stages_p)
  ) reset_sync (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .reset_n_o(reset_sync_n)
  );

  bsg_manycore_reset_seq_state_e state_q, state_n;
  logic [hold_w_lp-1:0] hold_q, hold_n;
  logic [gap_w_lp-1:0]  gap_q, gap_n;
  logic [row_w_lp-1:0]  row_q, row_n;
  logic [rows_lp-1:0]   released_q, released_n;
  logic [cols_lp-1:0]   io_reset_q, io_reset_n;
  logic [tiles_lp-1:0]  tile_reset_q, tile_reset_n;
  logic                 done_q, done_n;
  logic                 ready_q, ready_n;

  // Next-state, counter and output computation.
  always_comb begin
    state_n    = state_q;
    hold_n     = hold_q;
    gap_n      = gap_q;
    row_n      = row_q;
    released_n = released_q;
    io_reset_n = io_reset_q;
    done_n     = done_q;
    ready_n    = ready_q;

    unique case (state_q)
      e_rs_idle: begin
        if (reset_sync_n) begin
          state_n = e_rs_hold;
          hold_n  = '0;
        end
      end

      e_rs_hold: begin
        if (hold_q == hold_w_lp'(hold_cycles_p - 1)) begin
          io_reset_n = '0;
          hold_n     = '0;
          gap_n      = '0;
          state_n    = e_rs_io;
        end else begin
          hold_n = hold_q + hold_w_lp'(1);
        end
      end

      // IO waits out the first gap before row 0; ROWS releases the rest and
      // spends one extra cycle after the last row before reporting done.
      e_rs_io, e_rs_rows: begin
        if (state_q == e_rs_rows && row_q == row_w_lp'(rows_lp)) begin
          state_n = e_rs_done;
          done_n  = 1'b1;
          ready_n = 1'b1;
        end else if (gap_q == gap_w_lp'(row_gap_p - 1)) begin
          for (int unsigned k = 0; k < rows_lp; k++) begin
            if (row_q == row_w_lp'(k)) released_n[k] = 1'b1;
          end
          row_n   = row_q + row_w_lp'(1);
          gap_n   = '0;
          state_n = e_rs_rows;
        end else begin
          gap_n = gap_q + gap_w_lp'(1);
        end
      end

      // Software re-reset restarts at HOLD; the synchroniser is not re-run.
      e_rs_done: begin
        if (sw_reset_v_i && ready_q) begin
          state_n    = e_rs_hold;
          hold_n     = '0;
          gap_n      = '0;
          row_n      = '0;
          released_n = '0;
          io_reset_n = '1;
          done_n     = 1'b0;
          ready_n    = 1'b0;
        end
      end

      default: begin
        state_n = e_rs_idle;
      end
    endcase

    // A whole row's columns come out of reset together.
    for (int unsigned k = 0; k < rows_lp; k++) begin
`ifdef BSG_MANYCORE_RESET_SEQ_ROW_HOLD_EN
      tile_reset_n[k*cols_lp +: cols_lp] = {cols_lp{~released_n[k] | row_hold_i[k]}};
`else
      tile_reset_n[k*cols_lp +: cols_lp] = {cols_lp{~released_n[k]}};
`endif
    end
  end

  // State, counters and registered outputs; assertion is immediate.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= e_rs_idle;
      hold_q       <= '0;
      gap_q        <= '0;
      row_q        <= '0;
      released_q   <= '0;
      io_reset_q   <= '1;
      tile_reset_q <= '1;
      done_q       <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_n;
      hold_q       <= hold_n;
      gap_q        <= gap_n;
      row_q        <= row_n;
      released_q   <= released_n;
      io_reset_q   <= io_reset_n;
      tile_reset_q <= tile_reset_n;
      done_q       <= done_n;
      ready_q      <= ready_n;
    end
  end

  assign sw_reset_ready_o = ready_q;
  assign io_reset_o       = io_reset_q;
  assign tile_reset_o     = tile_reset_q;
  assign done_o           = done_q;

endmodule
